bcp_dispatch_scheduler: RTL and testbench

Sequencing controller for the BCP traversal engine. It buffers pending implications (literal value, bit offset, clause-list base, clause count) in a small FIFO. It walks each implication's clause list one word at a time, issuing one traversal request per clause word and waiting for completion. On a conflict it aborts and flushes the queue; otherwise it signals DONE when all pending work has drained.

---
 rtl/bcp_dispatch_scheduler_if.sv | 33 +++
 rtl/bcp_dispatch_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_bcp_dispatch_scheduler.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcp_dispatch_scheduler_if.sv
// Implication-in / traversal-out handshake bundle for bcp_dispatch_scheduler.
// slave = the scheduler, master = the surrounding environment.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

interface bcp_dispatch_scheduler_if #(
    parameter int CNT_W = 8
);
    logic                  lit_valid;
    logic                  lit_ready;
    logic [`ADDR_SIZE-1:0] lit_base;
    logic [CNT_W-1:0]      lit_cnt;
    logic [1:0]            lit_offset;
    logic                  lit_value;

    logic                  te_en;
    logic [`ADDR_SIZE-1:0] te_base;
    logic [1:0]            te_offset;
    logic                  te_value;
    logic                  te_done;
    logic                  te_conflict;

    modport slave (
        input  lit_valid, lit_base, lit_cnt, lit_offset, lit_value, te_done, te_conflict,
        output lit_ready, te_en, te_base, te_offset, te_value
    );

    modport master (
        output lit_valid, lit_base, lit_cnt, lit_offset, lit_value, te_done, te_conflict,
        input  lit_ready, te_en, te_base, te_offset, te_value
    );
endinterface

// File: rtl/bcp_dispatch_scheduler.sv
// BCP dispatch scheduler: queues implications and walks each clause list one word per request.
// Optional watchdog on the WAIT state is enabled by defining BCP_WATCHDOG_EN.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

module bcp_dispatch_scheduler #(
    parameter int QUEUE_DEPTH    = 8,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    bcp_dispatch_scheduler_if.slave bus,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    conflict_o,
    output logic [`ADDR_SIZE-1:0]   conflict_addr_o,
    output logic                    timeout_o
);
    localparam int AW = `ADDR_SIZE;
    localparam int PW = $clog2(QUEUE_DEPTH);

    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("QUEUE_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    typedef struct packed {
        logic [AW-1:0]    base;
        logic [CNT_W-1:0] cnt;
        logic [1:0]       offset;
        logic             value;
    } entry_t;

    typedef enum logic [2:0] {IDLE, POP, ISSUE, WAIT, ERR} state_e;

    state_e           state_q;
    entry_t           mem_q [QUEUE_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic [CNT_W-1:0] cnt_q, idx_q;
    logic [AW-1:0]    te_base_q, conflict_addr_q;
    logic [1:0]       te_offset_q;
    logic             te_value_q, te_en_q;
    logic             rdy_en_q, busy_q, done_q, conflict_q, timeout_q;

    logic   full, push, pop, abort, wd_fire, last_word, more_work;
    entry_t head;

`ifdef BCP_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt_q;

    // Counts cycles spent in WAIT; any other state re-arms it to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)               wd_cnt_q <= '0;
        else if (state_q != WAIT)  wd_cnt_q <= '0;
        else                       wd_cnt_q <= wd_cnt_q + TW'(1);
    end

    assign wd_fire = (state_q == WAIT) && !bus.te_done && (wd_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign wd_fire = 1'b0;
`endif

    assign full      = (count_q == (PW+1)'(QUEUE_DEPTH));
    assign head      = mem_q[rd_ptr_q];
    assign abort     = !clr_i && (state_q == WAIT) && ((bus.te_done && bus.te_conflict) || wd_fire);
    // Ready also drops on clear/abort so an accepted implication is never silently lost.
    assign bus.lit_ready = rdy_en_q && !full && (state_q != ERR) && !abort && !clr_i;
    assign push      = bus.lit_valid && bus.lit_ready;
    assign pop       = (state_q == POP);
    assign last_word = ((idx_q + CNT_W'(1)) == cnt_q);
    assign more_work = (count_q != '0) || push;

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {bus.lit_base, bus.lit_cnt, bus.lit_offset, bus.lit_value};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i || abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            idx_q           <= '0;
            te_base_q       <= '0;
            te_offset_q     <= '0;
            te_value_q      <= 1'b0;
            te_en_q         <= 1'b0;
            rdy_en_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            conflict_q      <= 1'b0;
            conflict_addr_q <= '0;
            timeout_q       <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            te_en_q  <= 1'b0;
            done_q   <= 1'b0;
            if (clr_i) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                conflict_q <= 1'b0;
                timeout_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (count_q != '0) begin
                        state_q <= POP;
                        busy_q  <= 1'b1;
                    end
                    POP: begin
                        // te_base_q doubles as the running word address base+index.
                        cnt_q       <= head.cnt;
                        idx_q       <= '0;
                        te_base_q   <= head.base;
                        te_offset_q <= head.offset;
                        te_value_q  <= head.value;
                        if (head.cnt == '0) begin
                            if ((count_q > (PW+1)'(1)) || push) begin
                                state_q <= POP;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            state_q <= ISSUE;
                            te_en_q <= 1'b1;
                        end
                    end
                    ISSUE: state_q <= WAIT;
                    WAIT: begin
                        if (wd_fire) begin
                            state_q   <= ERR;
                            timeout_q <= 1'b1;
                        end else if (bus.te_done) begin
                            if (bus.te_conflict) begin
                                state_q         <= ERR;
                                conflict_q      <= 1'b1;
                                conflict_addr_q <= te_base_q;
                            end else if (last_word) begin
                                if (more_work) begin
                                    state_q <= POP;
                                end else begin
                                    state_q <= IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                idx_q     <= idx_q + CNT_W'(1);
                                te_base_q <= te_base_q + AW'(1);
                                state_q   <= ISSUE;
                                te_en_q   <= 1'b1;
                            end
                        end
                    end
                    ERR:     state_q <= ERR;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.te_en     = te_en_q;
    assign bus.te_base   = te_base_q;
    assign bus.te_offset = te_offset_q;
    assign bus.te_value  = te_value_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign conflict_o      = conflict_q;
    assign conflict_addr_o = conflict_addr_q;
    assign timeout_o       = timeout_q;
endmodule

// File: tb/tb_bcp_dispatch_scheduler.sv
// Self-checking bench: a request queue expanded from accepted pushes predicts every TE_EN.
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif

module tb_bcp_dispatch_scheduler;
    localparam int QD = 8, CW = 8, TO = 64, AW = `ADDR_SIZE;

    typedef struct {
        logic [AW-1:0] base;
        logic [1:0]    off;
        logic          val;
    } req_t;

    logic          clk = 1'b0, rst_n = 1'b1, clr = 1'b0;
    logic          busy, done, conflict, timeout;
    logic [AW-1:0] conflict_addr;

    bcp_dispatch_scheduler_if #(.CNT_W(CW)) bus();

    bcp_dispatch_scheduler #(.QUEUE_DEPTH(QD), .CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus(bus),
        .busy_o(busy), .done_o(done), .conflict_o(conflict),
        .conflict_addr_o(conflict_addr), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    int            vectors = 0, errors = 0, cyc = 0;
    req_t          exp_q[$];
    logic [AW-1:0] te_log[$];
    int            te_cyc_log[$];
    int            done_cnt = 0, te_cnt = 0, hs_cyc = 0;
    bit            hold = 0, arm = 0;
    logic [AW-1:0] conf_target = '0;
    int            lat_min = 1, lat_max = 3, pend = 0;
    logic [AW-1:0] pend_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Compare process: every TE_EN must be the next predicted word, DONE only with nothing left.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (bus.te_en) begin
                req_t r;
                te_log.push_back(bus.te_base);
                te_cyc_log.push_back(cyc);
                te_cnt++;
                if (exp_q.size() == 0) check("te_en_unexpected", 1, 0);
                else begin
                    r = exp_q.pop_front();
                    check("te_base", bus.te_base, r.base);
                    check("te_offset", bus.te_offset, r.off);
                    check("te_value", bus.te_value, r.val);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_with_work_left", exp_q.size(), 0);
                check("busy_at_done", busy, 0);
            end
        end
    end

    // Traversal engine: answers each request lat cycles later unless held.
    initial begin
        bus.te_done = 1'b0;
        bus.te_conflict = 1'b0;
        forever begin
            @(negedge clk);
            bus.te_done = 1'b0;
            bus.te_conflict = 1'b0;
            if (!rst_n) pend = 0;
            else begin
                if (pend > 0 && !hold) begin
                    pend--;
                    if (pend == 0) begin
                        bus.te_done = 1'b1;
                        if (arm && pend_addr == conf_target) begin
                            bus.te_conflict = 1'b1;
                            exp_q.delete();
                            arm = 0;
                        end
                    end
                end
                if (bus.te_en) begin
                    pend = $urandom_range(lat_max, lat_min);
                    pend_addr = bus.te_base;
                end
            end
        end
    end

    task automatic push(input logic [AW-1:0] b, input int c, input logic [1:0] o, input logic v);
        int w = 0;
        req_t r;
        @(negedge clk);
        bus.lit_valid = 1'b1; bus.lit_base = b; bus.lit_cnt = CW'(c);
        bus.lit_offset = o; bus.lit_value = v;
        #1;
        while (!bus.lit_ready && w < 2000) begin @(negedge clk); #1; w++; end
        if (bus.lit_ready) begin
            for (int i = 0; i < c; i++) begin
                r.base = b + AW'(i); r.off = o; r.val = v;
                exp_q.push_back(r);
            end
            hs_cyc = cyc + 1;
            @(posedge clk); #1;
        end else check("push_timeout", 1, 0);
        bus.lit_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (((busy || exp_q.size() != 0) || n < 3) && n < limit);
        check(name, {busy, exp_q.size() != 0}, 2'b00);
    endtask

    task automatic wait_te(input int n0);
        int n = 0;
        while (te_cnt <= n0 && n < 200) begin @(negedge clk); n++; end
        check("wait_te", te_cnt > n0, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_te"}, {bus.te_en, bus.te_base, bus.te_offset, bus.te_value}, '0);
        check({name, "_status"}, {conflict, conflict_addr, timeout, bus.lit_ready}, '0);
    endtask

    initial begin
        int d0, t0, c0, sum;
        bus.lit_valid = 1'b0; bus.lit_base = '0; bus.lit_cnt = '0;
        bus.lit_offset = '0; bus.lit_value = 1'b0;

        #3 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_edge", bus.lit_ready, 0);
        @(posedge clk); #1 check("ready_after_edge", bus.lit_ready, 1);

        // Single implication, fixed 2-cycle engine.
        lat_min = 2; lat_max = 2; d0 = done_cnt;
        te_log.delete(); te_cyc_log.delete();
        push(AW'('h10), 3, 2'd2, 1'b1);
        wait_idle(200, "t1_idle");
        check("t1_ntes", te_log.size(), 3);
        if (te_log.size() == 3) begin
            check("t1_base0", te_log[0], AW'('h10));
            check("t1_base1", te_log[1], AW'('h11));
            check("t1_base2", te_log[2], AW'('h12));
            check("t1_first_latency", te_cyc_log[0] - hs_cyc, 2);
            check("t1_b2b_spacing", te_cyc_log[1] - te_cyc_log[0], 3);
        end
        check("t1_done_pulses", done_cnt - d0, 1);

        // Fill the FIFO behind a stalled request, then drain in order.
        lat_min = 1; lat_max = 3; d0 = done_cnt; t0 = te_cnt;
        hold = 1;
        push(AW'('hA00), 1, 2'd1, 1'b0);
        wait_te(t0);
        push(AW'('hB00), 2, 2'd0, 1'b1);
        push(AW'('hB10), 0, 2'd3, 1'b1);
        push(AW'('hB20), 1, 2'd2, 1'b0);
        push(AW'('hB30), 3, 2'd1, 1'b1);
        push(AW'('hB40), 1, 2'd0, 1'b0);
        push(AW'('hB50), 2, 2'd3, 1'b1);
        push(AW'('hB60), 1, 2'd2, 1'b1);
        push(AW'('hB70), 255, 2'd1, 1'b0);
        check("t2_ready_full", bus.lit_ready, 0);
        check("t2_busy", busy, 1);
        hold = 0;
        wait_idle(5000, "t2_idle");
        sum = 1 + 2 + 0 + 1 + 3 + 1 + 2 + 1 + 255;
        check("t2_te_total", te_cnt - t0, sum);
        check("t2_done_pulses", done_cnt - d0, 1);

        // Conflict on the second word of 0x40 with three entries behind it.
        lat_min = 2; lat_max = 2; d0 = done_cnt; t0 = te_cnt;
        conf_target = AW'('h41); arm = 1;
        push(AW'('h40), 3, 2'd0, 1'b1);
        push(AW'('h100), 2, 2'd1, 1'b0);
        push(AW'('h200), 1, 2'd2, 1'b1);
        push(AW'('h300), 4, 2'd3, 1'b0);
        c0 = 0;
        while (!conflict && c0 < 50) begin @(negedge clk); c0++; end
        check("t3_conflict", conflict, 1);
        check("t3_conflict_addr", conflict_addr, AW'('h41));
        check("t3_ready_err", bus.lit_ready, 0);
        repeat (10) @(negedge clk);
        check("t3_no_more_te", te_cnt - t0, 2);
        check("t3_still_busy", {busy, bus.lit_ready}, 2'b10);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1 check("t3_after_clr", {conflict, busy, bus.lit_ready}, 3'b001);
        repeat (6) @(negedge clk);
        check("t3_fifo_empty", {busy, 32'(te_cnt - t0)}, {1'b0, 32'd2});
        check("t3_no_done", done_cnt - d0, 0);

        // Address wrap.
        te_log.delete();
        push({AW{1'b1}}, 2, 2'd3, 1'b1);
        wait_idle(200, "t4_idle");
        check("t4_ntes", te_log.size(), 2);
        if (te_log.size() == 2) begin
            check("t4_base0", te_log[0], {AW{1'b1}});
            check("t4_base1", te_log[1], {AW{1'b0}});
        end

        // Asynchronous reset in the middle of WAIT with work queued.
        d0 = done_cnt; t0 = te_cnt; hold = 1;
        push(AW'('h500), 2, 2'd1, 1'b1);
        push(AW'('h600), 1, 2'd2, 1'b0);
        push(AW'('h700), 1, 2'd3, 1'b1);
        wait_te(t0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_q.delete();
        hold = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);
        push(AW'('h800), 2, 2'd0, 1'b1);
        wait_idle(200, "t5_idle");
        check("t5_done", done_cnt - d0, 1);

        // Withheld TE_DONE.
        hold = 1; t0 = te_cnt;
        push(AW'('h900), 1, 2'd1, 1'b1);
        wait_te(t0);
        c0 = te_cyc_log[te_cyc_log.size()-1];
`ifdef BCP_WATCHDOG_EN
        while (cyc < c0 + TO) @(negedge clk);
        check("t6_timeout_early", timeout, 0);
        @(negedge clk);
        check("t6_timeout", timeout, 1);
        check("t6_no_conflict", conflict, 0);
        check("t6_err_ready", {busy, bus.lit_ready}, 2'b10);
        hold = 0;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1 check("t6_after_clr", {timeout, busy, bus.lit_ready}, 3'b001);
        repeat (5) @(negedge clk);
`else
        while (cyc < c0 + 200) @(negedge clk);
        check("t6_busy_forever", {busy, timeout, conflict}, 3'b100);
        hold = 0;
        wait_idle(200, "t6_idle");
`endif

        // Randomized phases.
        for (int p = 0; p < 20; p++) begin
            int k;
            d0 = done_cnt;
            lat_min = 1; lat_max = $urandom_range(3, 1);
            k = $urandom_range(6, 1);
            for (int e = 0; e < k; e++) begin
                push(AW'($urandom), $urandom_range(5, 0), 2'($urandom), 1'($urandom));
                repeat ($urandom_range(4, 0)) @(negedge clk);
            end
            wait_idle(2000, "rand_idle");
            check("rand_done", done_cnt > d0, 1);
        end

`ifndef BCP_WATCHDOG_EN
        check("timeout_tied_low", timeout, 0);
`endif
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
